step_fifo: RTL and testbench

Per-step pulse counter and result buffer for the scan chain. It counts rising edges on the `count` input during a scan step framed by `startStep`/`stopStep`, and measures the step length in clock cycles. At the end of each step it pushes a {time, signals} record into a small FIFO. The Ethernet side drains the FIFO through `time_export`/`signals_export`/`cread`, and a status register on the shared 8-bit command bus lets software poll and clear the buffer.

---
 rtl/scan_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/step_fifo.sv | 152 +++++++++++++++
 tb/tb_step_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types for the scan-step pulse counter: FSM states, register map defaults, FIFO record.
// No logic of its own; no latency.
// No flow control of its own.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PUSH  = 2'd2
    } state_t;

    localparam logic [7:0] ADDR_STATUS_DEF = 8'h40;
    localparam logic [7:0] ADDR_CTRL_DEF   = 8'h41;
    localparam logic [7:0] ADDR_LEVEL_DEF  = 8'h42;

    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;

    typedef struct packed {
        logic [31:0] step_time;
        logic [31:0] signals;
    } rec_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush and fill level.
// Latency: a write is visible on o_rd_dat the cycle after it is accepted.
// Backpressure: a write to a full FIFO is dropped unless a pop completes in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_rdy,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_full   = (r_level == LW'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign o_level  = r_level;
    assign o_rd_dat = r_mem[r_rptr];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_do_rd = i_rd_rdy && !o_empty;
    assign w_do_wr = i_wr_vld && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush) begin
            r_mem[r_wptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + AW'(1);
            if (w_do_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/step_fifo.sv
// Counts synchronized count edges and cycles per scan step; queues {time, signals} per step.
// Latency: record visible on exports two cycles after stopStep (FIFO empty); count edge to counter 3 cycles.
// Backpressure: none upstream; a step finishing into a full FIFO is dropped and sets sticky overflow.
module step_fifo
    import scan_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter logic [7:0] ADDR_STATUS = ADDR_STATUS_DEF,
    parameter logic [7:0] ADDR_CTRL   = ADDR_CTRL_DEF,
    parameter logic [7:0] ADDR_LEVEL  = ADDR_LEVEL_DEF
) (
    input  logic        clock50Mhz,
    input  logic        key_restart,
    input  logic [7:0]  addr,
    input  logic [7:0]  data,
    input  logic        write,
    output logic [7:0]  data_out,
    input  logic        startStep,
    input  logic        stopStep,
    input  logic        cread,
    input  logic        count,
    output logic [31:0] time_export,
    output logic [31:0] signals_export,
    output logic        fifo_empty
);

    localparam int LW = $clog2(DEPTH + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic          r_edge;
    logic [31:0]   r_tcnt;
    logic [31:0]   r_scnt;
    logic          r_ovf;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_abort;
    logic          w_start;
    logic          w_push;
    logic          w_busy;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    rec_t          w_push_rec;
    rec_t          w_head_rec;
    logic          w_unused_data;

    assign w_unused_data = ^data[7:2];

    // Third flop holds the previous synchronized level; the edge pulse is registered.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= count;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    assign w_ctrl_wr = write && (addr == ADDR_CTRL);
    assign w_flush   = w_ctrl_wr && data[CTRL_FLUSH_BIT];
    assign w_abort   = w_ctrl_wr && data[CTRL_ABORT_BIT];
    assign w_start   = (r_state == IDLE) && startStep && !w_abort;
    assign w_push    = (r_state == PUSH) && !w_abort;
    assign w_busy    = (r_state != IDLE);

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (startStep) w_state_nxt = COUNT;
            COUNT:   if (stopStep)  w_state_nxt = PUSH;
            PUSH:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            r_tcnt <= '0;
            r_scnt <= '0;
        end else if (w_start) begin
            r_tcnt <= '0;
            r_scnt <= '0;
        end else if (r_state == COUNT) begin
            r_tcnt <= sat_inc(r_tcnt, 1'b1);
            r_scnt <= sat_inc(r_scnt, r_edge);
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO only overflows without cread.
    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            r_ovf <= 1'b0;
        end else if (w_flush) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !cread) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_push_rec.step_time = r_tcnt;
    assign w_push_rec.signals   = r_scnt;

    sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clock50Mhz),
        .rst_n    (key_restart),
        .i_flush  (w_flush),
        .i_wr_vld (w_push),
        .i_wr_dat (w_push_rec),
        .i_rd_rdy (cread),
        .o_rd_dat (w_head_rec),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (w_level)
    );

    assign fifo_empty     = w_empty;
    assign time_export    = w_empty ? 32'd0 : w_head_rec.step_time;
    assign signals_export = w_empty ? 32'd0 : w_head_rec.signals;

    always_comb begin
        data_out = 8'h00;
        if (addr == ADDR_STATUS) begin
            data_out = {r_ovf, w_full, w_empty, w_busy, 4'b0000};
        end else if (addr == ADDR_LEVEL) begin
            data_out = 8'(w_level);
        end
    end

endmodule

// File: tb/tb_step_fifo.sv
// Bench for step_fifo: table-driven steps with a record scoreboard plus hand-written corner sequences.
module tb_step_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        key_restart;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        write;
    logic [7:0]  data_out;
    logic        startStep;
    logic        stopStep;
    logic        cread;
    logic        count;
    logic [31:0] time_export;
    logic [31:0] signals_export;
    logic        fifo_empty;

    typedef struct {
        int          len;
        int          np;
        logic [31:0] exp_t;
        logic [31:0] exp_s;
    } step_vec_t;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] s;
    } exp_rec_t;

    step_vec_t vecs [9];
    exp_rec_t  sb [$];
    int        n_checks;
    int        n_errs;

    step_fifo #(.DEPTH(DEPTH)) dut (
        .clock50Mhz     (clk),
        .key_restart    (key_restart),
        .addr           (addr),
        .data           (data),
        .write          (write),
        .data_out       (data_out),
        .startStep      (startStep),
        .stopStep       (stopStep),
        .cread          (cread),
        .count          (count),
        .time_export    (time_export),
        .signals_export (signals_export),
        .fifo_empty     (fifo_empty)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(name, 32'(data_out), 32'(exp));
        addr = 8'h00;
    endtask

    task automatic chk_head(input string name);
        if (sb.size() == 0) begin
            chk({name, "_t"}, time_export, 32'd0);
            chk({name, "_s"}, signals_export, 32'd0);
            chk({name, "_e"}, 32'(fifo_empty), 32'd1);
        end else begin
            chk({name, "_t"}, time_export, sb[0].t);
            chk({name, "_s"}, signals_export, sb[0].s);
            chk({name, "_e"}, 32'(fifo_empty), 32'd0);
        end
    endtask

    task automatic pop_chk(input string name);
        chk_head({name, "_pre"});
        cread = 1'b1;
        tick();
        cread = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        chk_head({name, "_post"});
    endtask

    task automatic ctrl_write(input logic [7:0] v);
        addr  = 8'h41;
        data  = v;
        write = 1'b1;
        tick();
        write = 1'b0;
        addr  = 8'h00;
        data  = 8'h00;
        if (v[0]) sb.delete();
    endtask

    // startStep at cycle N, stopStep at N+len; returns in cycle N+len+2.
    task automatic run_step(input int len, input int np, input logic [31:0] et,
                            input logic [31:0] es, input bit pop_in_push, input bit flush_in_push);
        startStep = 1'b1;
        tick();
        startStep = 1'b0;
        for (int t = 1; t < len; t++) begin
            count = (t >= 2) && (((t - 2) / 8) < np) && (((t - 2) % 8) < 4);
            tick();
        end
        count    = 1'b0;
        stopStep = 1'b1;
        tick();
        stopStep = 1'b0;
        if (pop_in_push) cread = 1'b1;
        if (flush_in_push) begin
            addr  = 8'h41;
            data  = 8'h01;
            write = 1'b1;
        end
        tick();
        cread = 1'b0;
        write = 1'b0;
        addr  = 8'h00;
        data  = 8'h00;
        if (flush_in_push) begin
            sb.delete();
        end else begin
            if (pop_in_push && sb.size() > 0) void'(sb.pop_front());
            if (sb.size() < DEPTH) sb.push_back('{t: et, s: es});
        end
    endtask

    initial begin
        vecs = '{'{10, 1, 32'd10, 32'd1}, '{12, 0, 32'd12, 32'd0}, '{17, 2, 32'd17, 32'd2},
                 '{9, 1, 32'd9, 32'd1},   '{30, 3, 32'd30, 32'd3}, '{1, 0, 32'd1, 32'd0},
                 '{25, 3, 32'd25, 32'd3}, '{40, 4, 32'd40, 32'd4}, '{16, 2, 32'd16, 32'd2}};
        n_checks    = 0;
        n_errs      = 0;
        key_restart = 1'b0;
        addr        = 8'h00;
        data        = 8'h00;
        write       = 1'b0;
        startStep   = 1'b0;
        stopStep    = 1'b0;
        cread       = 1'b0;
        count       = 1'b0;
        repeat (3) @(posedge clk);
        #1 key_restart = 1'b1;
        tick();

        chk_reg("rst_status", 8'h40, 8'h20);
        chk_reg("rst_level", 8'h42, 8'h00);
        chk_reg("rst_other", 8'h43, 8'h00);
        chk_head("rst_head");

        run_step(100, 5, 32'd100, 32'd5, 1'b0, 1'b0);
        chk_head("step100");
        chk_reg("step100_status", 8'h40, 8'h00);
        pop_chk("pop100");

        cread = 1'b1;
        tick();
        cread = 1'b0;
        chk_reg("cread_empty_level", 8'h42, 8'h00);
        chk_head("cread_empty_head");

        foreach (vecs[i]) begin
            run_step(vecs[i].len, vecs[i].np, vecs[i].exp_t, vecs[i].exp_s, 1'b0, 1'b0);
        end
        chk_reg("nine_level", 8'h42, 8'h08);
        chk_reg("nine_status", 8'h40, 8'hC0);
        for (int i = 0; i < DEPTH; i++) begin
            pop_chk("nine_pop");
        end
        chk_reg("drained_status", 8'h40, 8'hA0);
        ctrl_write(8'h01);
        chk_reg("flush_status", 8'h40, 8'h20);

        for (int i = 0; i < DEPTH; i++) begin
            run_step(vecs[i].len, vecs[i].np, vecs[i].exp_t, vecs[i].exp_s, 1'b0, 1'b0);
        end
        run_step(20, 2, 32'd20, 32'd2, 1'b1, 1'b0);
        chk_reg("pushpop_level", 8'h42, 8'h08);
        chk_reg("pushpop_status", 8'h40, 8'h40);
        chk_head("pushpop_head");
        ctrl_write(8'h01);
        chk_reg("pushpop_flush_level", 8'h42, 8'h00);

        run_step(11, 1, 32'd11, 32'd1, 1'b0, 1'b0);
        startStep = 1'b1;
        tick();
        startStep = 1'b0;
        repeat (5) tick();
        chk_reg("abort_busy", 8'h40, 8'h10);
        ctrl_write(8'h02);
        chk_reg("abort_status", 8'h40, 8'h00);
        stopStep = 1'b1;
        tick();
        stopStep = 1'b0;
        repeat (3) tick();
        chk_reg("abort_level", 8'h42, 8'h01);
        chk_head("abort_head");
        ctrl_write(8'h01);
        chk_reg("abort_flush_level", 8'h42, 8'h00);
        chk_reg("abort_flush_status", 8'h40, 8'h20);

        startStep = 1'b1;
        stopStep  = 1'b1;
        tick();
        startStep = 1'b0;
        stopStep  = 1'b0;
        repeat (9) tick();
        stopStep = 1'b1;
        tick();
        stopStep = 1'b0;
        tick();
        tick();
        sb.push_back('{t: 32'd10, s: 32'd0});
        repeat (4) tick();
        chk_reg("both_level", 8'h42, 8'h01);
        chk_head("both_head");
        pop_chk("both_pop");

        run_step(15, 1, 32'd15, 32'd1, 1'b0, 1'b1);
        chk_reg("flushpush_level", 8'h42, 8'h00);
        chk_reg("flushpush_status", 8'h40, 8'h20);
        chk_head("flushpush_head");

        run_step(12, 1, 32'd12, 32'd1, 1'b0, 1'b0);
        startStep = 1'b1;
        tick();
        startStep = 1'b0;
        count = 1'b1;
        repeat (6) tick();
        #5 key_restart = 1'b0;
        sb.delete();
        chk_reg("rstmid_status", 8'h40, 8'h20);
        #3 key_restart = 1'b1;
        count = 1'b0;
        tick();
        stopStep = 1'b1;
        tick();
        stopStep = 1'b0;
        repeat (3) tick();
        chk_reg("rstmid_level", 8'h42, 8'h00);
        chk_reg("rstmid_status2", 8'h40, 8'h20);
        chk_head("rstmid_head");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
